// File: rtl/inst_prefetch_buf_pkg.sv
// Shared constants for the instruction prefetch buffer slice.
package inst_prefetch_buf_pkg;

    localparam logic [31:0] INST_NOP  = 32'h0000_0013;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/inst_prefetch_buf_if.sv
// Memory fetch port plus the instruction stream towards the core.
interface inst_prefetch_buf_if;

    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_ready_i;

    modport master (
        output mem_req_o, mem_addr_o, inst_valid_o, inst_o, inst_addr_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, inst_ready_i
    );

    modport slave (
        input  mem_req_o, mem_addr_o, inst_valid_o, inst_o, inst_addr_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i, inst_ready_i
    );

endinterface

// File: rtl/inst_prefetch_buf_fifo.sv
// Synchronous FIFO holding {addr, inst} pairs; head is read straight from storage (no bypass).
module ipb_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64,
    localparam int unsigned PW = $clog2(DEPTH),
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             full;

    assign full      = (count == CW'(DEPTH));
    assign head_data = store[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            assert (!(push && full)) else $error("ipb_fifo: push while full");
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) store[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/inst_prefetch_buf.sv
// Instruction prefetch buffer: owns the fetch PC, issues credit-limited in-order fetches,
// queues returned words with their addresses and drops stale responses after a redirect.
module inst_prefetch_buf
    import inst_prefetch_buf_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    input  logic [31:0]          flush_addr_i,
    inst_prefetch_buf_if.master  bus
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [31:0]   fetch_pc;
    logic [31:0]   return_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_next;
    logic [CW-1:0] discard;
    logic [CW-1:0] count;
    logic [CW:0]   in_use;
    logic [63:0]   head;
    logic          grant;
    logic          push;
    logic          pop;
    logic          valid;

    always_comb begin
        in_use           = {1'b0, count} + {1'b0, outstanding};
        bus.mem_req_o    = !rst && !flush_i && (in_use < (CW+1)'(DEPTH));
        bus.mem_addr_o   = fetch_pc;
        grant            = bus.mem_req_o && bus.mem_gnt_i;
        // a response landing in the redirect cycle is stale, as is anything still owed to discard
        push             = !rst && bus.mem_rvalid_i && !flush_i && (discard == '0);
        valid            = !rst && !flush_i && (count != '0);
        pop              = valid && bus.inst_ready_i;
        outstanding_next = outstanding + CW'(grant) - CW'(bus.mem_rvalid_i);
        bus.inst_valid_o = valid;
        bus.inst_o       = valid ? head[31:0]  : INST_NOP;
        bus.inst_addr_o  = valid ? head[63:32] : ZERO_WORD;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            return_pc   <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (flush_i) begin
                fetch_pc  <= flush_addr_i;
                return_pc <= flush_addr_i;
                discard   <= outstanding_next;
            end else begin
                if (grant) fetch_pc <= pc_next(fetch_pc);
                if (push)  return_pc <= pc_next(return_pc);
                if (bus.mem_rvalid_i && (discard != '0)) discard <= discard - CW'(1);
            end
        end
    end

    ipb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush_i),
        .push      (push),
        .pop       (pop),
        .push_data ({return_pc, bus.mem_rdata_i}),
        .head_data (head),
        .count     (count)
    );

endmodule
